// File: rtl/memory_arbiter_controller_if.sv
// Client-side and driver-side bus of memory_arbiter_controller.
// slave: the arbiter's view; master: the clients/driver view.
interface memory_arbiter_controller_if #(
  parameter int NUM_PORTS  = 4,
  parameter int ADDR_WIDTH = 22,
  parameter int DATA_WIDTH = 16
);
  logic [NUM_PORTS-1:0]              port_rd;
  logic [NUM_PORTS-1:0]              port_wr;
  logic [NUM_PORTS*ADDR_WIDTH-1:0]   port_addr;
  logic [NUM_PORTS*DATA_WIDTH-1:0]   port_din;
  logic [NUM_PORTS*DATA_WIDTH/8-1:0] port_wdm;
  logic [NUM_PORTS-1:0]              port_ack;
  logic [NUM_PORTS-1:0]              port_rvalid;
  logic [NUM_PORTS*DATA_WIDTH-1:0]   port_dout;
  logic                              busy;
  logic                              fail;
  logic                              mem_rd;
  logic                              mem_wr;
  logic                              mem_refresh;
  logic [ADDR_WIDTH-1:0]             mem_addr;
  logic [DATA_WIDTH-1:0]             mem_din;
  logic [DATA_WIDTH/8-1:0]           mem_wdm;
  logic [DATA_WIDTH-1:0]             mem_dout;
  logic                              mem_busy;
  logic                              mem_data_ready;
  logic                              mem_enabled;

  modport slave (
    input  port_rd, port_wr, port_addr, port_din, port_wdm,
    input  mem_dout, mem_busy, mem_data_ready, mem_enabled,
    output port_ack, port_rvalid, port_dout, busy, fail,
    output mem_rd, mem_wr, mem_refresh, mem_addr, mem_din, mem_wdm
  );

  modport master (
    output port_rd, port_wr, port_addr, port_din, port_wdm,
    output mem_dout, mem_busy, mem_data_ready, mem_enabled,
    input  port_ack, port_rvalid, port_dout, busy, fail,
    input  mem_rd, mem_wr, mem_refresh, mem_addr, mem_din, mem_wdm
  );
endinterface

// File: rtl/memory_arbiter_controller.sv
// N-port arbiter in front of one sdram driver, with refresh timer and read-ready check.
// Define MEMCTL_ROUND_ROBIN_EN for round-robin arbitration (default: fixed, lowest index wins).
// state   | meaning
// ST_INIT | waiting for driver enabled and not busy
// ST_IDLE | refresh or port grant may be issued
// ST_OP   | command in flight, counter 1..OP_CYCLES
module memory_arbiter_controller #(
  parameter int NUM_PORTS        = 4,
  parameter int ADDR_WIDTH       = 22,
  parameter int DATA_WIDTH       = 16,
  parameter int OP_CYCLES        = 4,
  parameter int REFRESH_INTERVAL = 405
) (
  input  logic                          clk,
  input  logic                          resetn,
  memory_arbiter_controller_if.slave    bus
);
  localparam int MW = DATA_WIDTH / 8;
  localparam int IW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int CW = $clog2(OP_CYCLES + 1);
  localparam int RW = (REFRESH_INTERVAL > 1) ? $clog2(REFRESH_INTERVAL) : 1;

  typedef enum logic [1:0] {ST_INIT, ST_IDLE, ST_OP} state_t;

  state_t                        state_q, state_d;
  logic [CW-1:0]                 cnt_q, cnt_d;
  logic [IW-1:0]                 grant_q, grant_d;
  logic                          rd_op_q, rd_op_d;
  logic [RW-1:0]                 rfsh_cnt_q, rfsh_cnt_d;
  logic                          rfsh_pend_q, rfsh_pend_d;
  logic                          fail_q, fail_d;
  logic [NUM_PORTS-1:0]          ack_q, ack_d;
  logic [NUM_PORTS-1:0]          rvalid_q, rvalid_d;
  logic                          mem_rd_q, mem_rd_d;
  logic                          mem_wr_q, mem_wr_d;
  logic                          mem_refresh_q, mem_refresh_d;
  logic [ADDR_WIDTH-1:0]         mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0]         mem_din_q, mem_din_d;
  logic [MW-1:0]                 mem_wdm_q, mem_wdm_d;
  logic [NUM_PORTS*DATA_WIDTH-1:0] dout_q, dout_d;
`ifdef MEMCTL_ROUND_ROBIN_EN
  logic [IW-1:0]                 ptr_q, ptr_d;
`endif

  logic [NUM_PORTS-1:0]  req;
  logic [IW-1:0]         gnt_idx;
  logic [IW-1:0]         idx;
  logic                  sel_rd, sel_wr;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_din;
  logic [MW-1:0]         sel_wdm;
  logic                  rfsh_take;

  assign req = bus.port_rd | bus.port_wr;

  // Scan from lowest to highest priority so the highest-priority requester is written last.
  always_comb begin
    gnt_idx = '0;
    idx     = '0;
    for (int k = NUM_PORTS - 1; k >= 0; k--) begin
`ifdef MEMCTL_ROUND_ROBIN_EN
      idx = IW'((int'(ptr_q) + k) % NUM_PORTS);
`else
      idx = IW'(k);
`endif
      if (req[idx]) gnt_idx = idx;
    end
  end

  always_comb begin
    sel_rd   = 1'b0;
    sel_wr   = 1'b0;
    sel_addr = '0;
    sel_din  = '0;
    sel_wdm  = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      if (gnt_idx == IW'(k)) begin
        sel_rd   = bus.port_rd[k];
        sel_wr   = bus.port_wr[k];
        sel_addr = bus.port_addr[k*ADDR_WIDTH +: ADDR_WIDTH];
        sel_din  = bus.port_din[k*DATA_WIDTH +: DATA_WIDTH];
        sel_wdm  = bus.port_wdm[k*MW +: MW];
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    grant_d       = grant_q;
    rd_op_d       = rd_op_q;
    rfsh_pend_d   = rfsh_pend_q;
    rfsh_cnt_d    = rfsh_cnt_q;
    fail_d        = fail_q;
    ack_d         = '0;
    rvalid_d      = '0;
    mem_rd_d      = 1'b0;
    mem_wr_d      = 1'b0;
    mem_refresh_d = 1'b0;
    mem_addr_d    = mem_addr_q;
    mem_din_d     = mem_din_q;
    mem_wdm_d     = mem_wdm_q;
    dout_d        = dout_q;
    rfsh_take     = 1'b0;
`ifdef MEMCTL_ROUND_ROBIN_EN
    ptr_d         = ptr_q;
`endif
    unique case (state_q)
      ST_INIT: begin
        if (bus.mem_enabled && !bus.mem_busy) state_d = ST_IDLE;
      end
      ST_IDLE: begin
        if (rfsh_pend_q) begin
          rfsh_take     = 1'b1;
          mem_refresh_d = 1'b1;
          rd_op_d       = 1'b0;
          cnt_d         = CW'(1);
          state_d       = ST_OP;
        end else if (|req) begin
          grant_d          = gnt_idx;
          ack_d[gnt_idx]   = 1'b1;
          mem_addr_d       = sel_addr;
          mem_din_d        = sel_din;
          mem_wdm_d        = sel_wdm;
          // A port asking for both gets a write plus the error flag.
          mem_wr_d         = sel_wr;
          mem_rd_d         = !sel_wr;
          rd_op_d          = !sel_wr;
          if (sel_rd && sel_wr) fail_d = 1'b1;
`ifdef MEMCTL_ROUND_ROBIN_EN
          ptr_d            = IW'((int'(gnt_idx) + 1) % NUM_PORTS);
`endif
          cnt_d            = CW'(1);
          state_d          = ST_OP;
        end
      end
      ST_OP: begin
        if (cnt_q == CW'(OP_CYCLES)) begin
          state_d = ST_IDLE;
          if (rd_op_q) begin
            rvalid_d[grant_q] = 1'b1;
            for (int k = 0; k < NUM_PORTS; k++) begin
              if (grant_q == IW'(k)) dout_d[k*DATA_WIDTH +: DATA_WIDTH] = bus.mem_dout;
            end
            if (!bus.mem_data_ready) fail_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = ST_INIT;
    endcase

    if (rfsh_take) rfsh_pend_d = 1'b0;
    if (rfsh_cnt_q == '0) begin
      rfsh_cnt_d  = RW'(REFRESH_INTERVAL - 1);
      if (rfsh_pend_q && !rfsh_take) fail_d = 1'b1;
      rfsh_pend_d = 1'b1;
    end else begin
      rfsh_cnt_d  = rfsh_cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q       <= ST_INIT;
      cnt_q         <= '0;
      grant_q       <= '0;
      rd_op_q       <= 1'b0;
      rfsh_cnt_q    <= RW'(REFRESH_INTERVAL - 1);
      rfsh_pend_q   <= 1'b0;
      fail_q        <= 1'b0;
      ack_q         <= '0;
      rvalid_q      <= '0;
      mem_rd_q      <= 1'b0;
      mem_wr_q      <= 1'b0;
      mem_refresh_q <= 1'b0;
      mem_addr_q    <= '0;
      mem_din_q     <= '0;
      mem_wdm_q     <= '0;
      dout_q        <= '0;
`ifdef MEMCTL_ROUND_ROBIN_EN
      ptr_q         <= '0;
`endif
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      grant_q       <= grant_d;
      rd_op_q       <= rd_op_d;
      rfsh_cnt_q    <= rfsh_cnt_d;
      rfsh_pend_q   <= rfsh_pend_d;
      fail_q        <= fail_d;
      ack_q         <= ack_d;
      rvalid_q      <= rvalid_d;
      mem_rd_q      <= mem_rd_d;
      mem_wr_q      <= mem_wr_d;
      mem_refresh_q <= mem_refresh_d;
      mem_addr_q    <= mem_addr_d;
      mem_din_q     <= mem_din_d;
      mem_wdm_q     <= mem_wdm_d;
      dout_q        <= dout_d;
`ifdef MEMCTL_ROUND_ROBIN_EN
      ptr_q         <= ptr_d;
`endif
    end
  end

  assign bus.port_ack    = ack_q;
  assign bus.port_rvalid = rvalid_q;
  assign bus.port_dout   = dout_q;
  assign bus.busy        = (state_q != ST_IDLE);
  assign bus.fail        = fail_q;
  assign bus.mem_rd      = mem_rd_q;
  assign bus.mem_wr      = mem_wr_q;
  assign bus.mem_refresh = mem_refresh_q;
  assign bus.mem_addr    = mem_addr_q;
  assign bus.mem_din     = mem_din_q;
  assign bus.mem_wdm     = mem_wdm_q;
endmodule

// File: tb/tb_memory_arbiter_controller.sv
// Directed bench for memory_arbiter_controller: one instance at the default refresh
// interval for handshake/arbitration, one at interval 20 for refresh spacing.
module tb_memory_arbiter_controller;
  localparam int NP  = 4;
  localparam int AW  = 22;
  localparam int DW  = 16;
  localparam int OPC = 4;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  memory_arbiter_controller_if #(.NUM_PORTS(NP), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus_a ();
  memory_arbiter_controller_if #(.NUM_PORTS(NP), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus_r ();

  memory_arbiter_controller #(.NUM_PORTS(NP), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
    .OP_CYCLES(OPC), .REFRESH_INTERVAL(405)) dut (.clk(clk), .resetn(resetn), .bus(bus_a));

  memory_arbiter_controller #(.NUM_PORTS(NP), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
    .OP_CYCLES(OPC), .REFRESH_INTERVAL(20)) dut_r (.clk(clk), .resetn(resetn), .bus(bus_r));

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // Ack was observed at the current step; op returns to IDLE OP_CYCLES steps later.
  task automatic op_finish(input string tag);
    repeat (OPC - 1) step();
    check({tag, "_busy_op"}, bus_a.busy, 1'b1);
    step();
    check({tag, "_busy_idle"}, bus_a.busy, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int got, last, nref, first_ref, acks;
    logic [NP-1:0] exp_ack;

    bus_a.port_rd = '0; bus_a.port_wr = '0; bus_a.port_addr = '0; bus_a.port_din = '0;
    bus_a.port_wdm = '0; bus_a.mem_dout = '0; bus_a.mem_busy = 1'b0;
    bus_a.mem_data_ready = 1'b0; bus_a.mem_enabled = 1'b0;
    bus_r.port_rd = '0; bus_r.port_wr = '0; bus_r.port_addr = '0; bus_r.port_din = '0;
    bus_r.port_wdm = '0; bus_r.mem_dout = '0; bus_r.mem_busy = 1'b0;
    bus_r.mem_data_ready = 1'b0; bus_r.mem_enabled = 1'b0;

    resetn = 1'b0;
    repeat (3) step();
    check("rst_busy", bus_a.busy, 1'b1);
    check("rst_outs", {bus_a.port_ack, bus_a.port_rvalid, bus_a.mem_rd, bus_a.mem_wr,
                       bus_a.mem_refresh, bus_a.fail, bus_a.mem_addr, bus_a.mem_din,
                       bus_a.mem_wdm}, 64'h0);
    check("rst_dout", bus_a.port_dout, 64'h0);

    // INIT: stays busy and silent until mem_enabled at cycle 100
    resetn = 1'b1;
    for (int c = 1; c <= 100; c++) begin
      step();
      check("init_busy", bus_a.busy, 1'b1);
      check("init_quiet", {bus_a.port_ack, bus_a.mem_rd, bus_a.mem_wr, bus_a.mem_refresh,
                           bus_a.mem_addr, bus_a.mem_din}, 64'h0);
    end
    bus_a.mem_enabled = 1'b1;
    step();
    check("init_exit_busy", bus_a.busy, 1'b0);

    // Port 1 write
    bus_a.port_wr = 4'b0010;
    bus_a.port_addr[1*AW +: AW] = 22'h000123;
    bus_a.port_din[1*DW +: DW] = 16'hA55A;
    bus_a.port_wdm[1*2 +: 2] = 2'b11;
    step();
    check("wr_cmd", {bus_a.mem_wr, bus_a.mem_rd, bus_a.mem_refresh}, 3'b100);
    check("wr_ack", bus_a.port_ack, 4'b0010);
    check("wr_addr", bus_a.mem_addr, 22'h000123);
    check("wr_din", bus_a.mem_din, 16'hA55A);
    check("wr_wdm", bus_a.mem_wdm, 2'b11);
    bus_a.port_wr = '0;
    op_finish("wr");

    // Port 2 read, data ready
    bus_a.mem_dout = 16'h1234;
    bus_a.mem_data_ready = 1'b1;
    bus_a.port_rd = 4'b0100;
    bus_a.port_addr[2*AW +: AW] = 22'h3FFFFF;
    step();
    check("rd_cmd", {bus_a.mem_wr, bus_a.mem_rd, bus_a.mem_refresh}, 3'b010);
    check("rd_ack", bus_a.port_ack, 4'b0100);
    check("rd_addr", bus_a.mem_addr, 22'h3FFFFF);
    bus_a.port_rd = '0;
    repeat (OPC - 1) step();
    check("rd_rvalid_early", bus_a.port_rvalid, 4'b0000);
    step();
    check("rd_rvalid", bus_a.port_rvalid, 4'b0100);
    check("rd_dout", bus_a.port_dout, {16'h0, 16'h1234, 16'h0, 16'h0});
    check("rd_fail", bus_a.fail, 1'b0);
    check("rd_idle", bus_a.busy, 1'b0);
    step();
    check("rd_rvalid_pulse", bus_a.port_rvalid, 4'b0000);
    check("rd_dout_hold", bus_a.port_dout, {16'h0, 16'h1234, 16'h0, 16'h0});

    // Port 2 read, data not ready at the sample point
    bus_a.mem_dout = 16'hBEEF;
    bus_a.mem_data_ready = 1'b0;
    bus_a.port_rd = 4'b0100;
    step();
    check("rdnr_ack", bus_a.port_ack, 4'b0100);
    bus_a.port_rd = '0;
    repeat (OPC - 1) step();
    check("rdnr_fail_before", bus_a.fail, 1'b0);
    step();
    check("rdnr_rvalid", bus_a.port_rvalid, 4'b0100);
    check("rdnr_dout", bus_a.port_dout, {16'h0, 16'hBEEF, 16'h0, 16'h0});
    check("rdnr_fail", bus_a.fail, 1'b1);
    step();
    check("rdnr_fail_sticky", bus_a.fail, 1'b1);

    // Reset asserted during a read's OP
    bus_a.mem_data_ready = 1'b1;
    bus_a.mem_dout = 16'h7777;
    bus_a.port_rd = 4'b0100;
    step();
    check("rstop_ack", bus_a.port_ack, 4'b0100);
    bus_a.port_rd = '0;
    step();
    #1 resetn = 1'b0;
    #1;
    check("rstop_busy", bus_a.busy, 1'b1);
    check("rstop_outs", {bus_a.port_ack, bus_a.port_rvalid, bus_a.mem_rd, bus_a.mem_wr,
                         bus_a.mem_refresh, bus_a.fail, bus_a.mem_addr, bus_a.mem_din,
                         bus_a.mem_wdm}, 64'h0);
    check("rstop_dout", bus_a.port_dout, 64'h0);
    repeat (5) begin
      step();
      check("rstop_no_rvalid", bus_a.port_rvalid, 4'b0000);
      check("rstop_hold_busy", bus_a.busy, 1'b1);
    end
    resetn = 1'b1;
    step();
    check("rstop_idle", bus_a.busy, 1'b0);
    check("rstop_rvalid_after", bus_a.port_rvalid, 4'b0000);

    // Port 3 asserts rd and wr together: write, ack, fail
    check("both_fail_before", bus_a.fail, 1'b0);
    bus_a.port_rd = 4'b1000;
    bus_a.port_wr = 4'b1000;
    step();
    check("both_cmd", {bus_a.mem_wr, bus_a.mem_rd, bus_a.mem_refresh}, 3'b100);
    check("both_ack", bus_a.port_ack, 4'b1000);
    check("both_fail", bus_a.fail, 1'b1);
    bus_a.port_rd = '0;
    bus_a.port_wr = '0;
    op_finish("both");

    // Ports 0 and 3 requesting continuously
    bus_a.port_wr = 4'b1001;
    got = 0;
    last = -1;
    for (int t = 1; t <= 60 && got < 6; t++) begin
      step();
      if (bus_a.port_ack != '0) begin
`ifdef MEMCTL_ROUND_ROBIN_EN
        exp_ack = (got % 2 == 0) ? 4'b0001 : 4'b1000;
`else
        exp_ack = 4'b0001;
`endif
        check("arb_ack", bus_a.port_ack, exp_ack);
        if (last >= 0) check("arb_gap", 64'(t - last), 64'(OPC + 1));
        last = t;
        got++;
      end
    end
    check("arb_count", 64'(got), 64'd6);
    bus_a.port_wr = '0;
    repeat (OPC + 2) step();

    // Refresh spacing under saturation (REFRESH_INTERVAL = 20)
    resetn = 1'b0;
    bus_r.mem_enabled = 1'b1;
    bus_r.mem_data_ready = 1'b1;
    bus_r.port_wr = 4'b1111;
    repeat (2) step();
    resetn = 1'b1;
    nref = 0;
    last = -1;
    first_ref = -1;
    acks = 0;
    for (int t = 1; t <= 210; t++) begin
      step();
      if (bus_r.mem_refresh) begin
        if (last >= 0) check("rfsh_gap_in_window",
                             64'((t - last >= 20 - (OPC + 1)) && (t - last <= 20 + (OPC + 1))), 64'd1);
        else first_ref = t;
        last = t;
        nref++;
      end
      if (bus_r.port_ack != '0) acks++;
    end
    check("rfsh_first_in_window", 64'((first_ref >= 21) && (first_ref <= 20 + OPC + 1)), 64'd1);
    check("rfsh_count", 64'(nref), 64'd10);
    check("rfsh_ports_served", 64'(acks > 20), 64'd1);
    check("rfsh_fail", bus_r.fail, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
